// File: rtl/radix_8_ntt_pipe.sv
// radix_8_ntt_pipe: streaming radix-8 NTT butterfly, DIF/DIT selectable per beat.
// Inverse transform (W8INV twiddles, 1/8 scaling) is built when RADIX8_NTT_INV_EN is defined.
module radix_8_ntt_pipe #(
  parameter int unsigned LOGQ     = 17,
  parameter int unsigned Q        = 65537,
  parameter int unsigned W8       = 16,
  parameter int unsigned W8INV    = 61441,
  parameter int unsigned EIGHTINV = 57345
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic              in_inv,
  input  logic [8*LOGQ-1:0] in_a,
  input  logic [8*LOGQ-1:0] in_tf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*LOGQ-1:0] out_a
);

  typedef logic [LOGQ-1:0] coef_t;
  typedef coef_t [7:0] vec_t;
  typedef coef_t [3:0] quad_t;

  localparam logic [LOGQ:0]     QX = (LOGQ+1)'(Q);
  localparam logic [2*LOGQ-1:0] QW = (2*LOGQ)'(Q);
  localparam coef_t             QN = LOGQ'(Q);

  function automatic coef_t cmul(input longint unsigned a,
                                 input longint unsigned b);
    return LOGQ'((a * b) % 64'(Q));
  endfunction

  function automatic coef_t mmul(input coef_t a, input coef_t b);
    logic [2*LOGQ-1:0] p;
    p = (2*LOGQ)'(a) * (2*LOGQ)'(b);
    return LOGQ'(p % QW);
  endfunction

  function automatic coef_t madd(input coef_t a, input coef_t b);
    logic [LOGQ:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return s[LOGQ-1:0];
  endfunction

  function automatic coef_t msub(input coef_t a, input coef_t b);
    logic [LOGQ:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + QX;
    return d[LOGQ-1:0];
  endfunction

  // One subtraction suffices because 2^LOGQ < 2Q.
  function automatic coef_t red(input coef_t a);
    return (a >= QN) ? a - QN : a;
  endfunction

  // 4-point transform with root v, where v^2 = -1; natural order out.
  function automatic quad_t dft4(input quad_t x, input coef_t v);
    coef_t e0, e1, f0, f1;
    quad_t r;
    e0 = madd(x[0], x[2]);
    e1 = madd(x[1], x[3]);
    f0 = msub(x[0], x[2]);
    f1 = mmul(msub(x[1], x[3]), v);
    r[0] = madd(e0, e1);
    r[1] = madd(f0, f1);
    r[2] = msub(e0, e1);
    r[3] = msub(f0, f1);
    return r;
  endfunction

  localparam coef_t WF1 = LOGQ'(W8);
  localparam coef_t WF2 = cmul(64'(W8), 64'(W8));
  localparam coef_t WF3 = cmul(64'(WF2), 64'(W8));

  logic inv_in;
  logic i0, i1, i2, i3;

`ifdef RADIX8_NTT_INV_EN
  localparam coef_t WI1 = LOGQ'(W8INV);
  localparam coef_t WI2 = cmul(64'(W8INV), 64'(W8INV));
  localparam coef_t WI3 = cmul(64'(WI2), 64'(W8INV));
  localparam coef_t EI  = LOGQ'(EIGHTINV);
  assign inv_in = in_inv;
`else
  logic unused_cfg;
  assign inv_in = 1'b0;
  assign unused_cfg = ^{in_inv, i3, W8INV, EIGHTINV};
`endif

  logic adv;
  logic v0, v1, v2, v3;
  logic m0, m1, m2, m3;
  vec_t a0r, t0r, d1, t1, d2, t2, d3, t3;
  vec_t s1a, s1t, s2, s3, s4p, s4;
  quad_t ev, od;
  coef_t k1, k2, k3;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1a = '0;
    s1t = '0;
    for (int k = 0; k < 8; k++) begin
      s1t[k] = red(t0r[k]);
      s1a[k] = m0 ? mmul(red(a0r[k]), red(t0r[k])) : red(a0r[k]);
    end
  end

  always_comb begin
    s2 = '0;
    for (int j = 0; j < 4; j++) begin
      s2[j]   = madd(d1[j], d1[j+4]);
      s2[j+4] = msub(d1[j], d1[j+4]);
    end
  end

  // Even outputs: 4-point DFT of the sums; odd: of the w^j-scaled differences.
  always_comb begin
    k1 = WF1;
    k2 = WF2;
    k3 = WF3;
`ifdef RADIX8_NTT_INV_EN
    if (i2) begin
      k1 = WI1;
      k2 = WI2;
      k3 = WI3;
    end
`endif
    ev = dft4({d2[3], d2[2], d2[1], d2[0]}, k2);
    od = dft4({mmul(d2[7], k3), mmul(d2[6], k2),
               mmul(d2[5], k1), d2[4]}, k2);
    s3 = {od[3], ev[3], od[2], ev[2],
          od[1], ev[1], od[0], ev[0]};
  end

  always_comb begin
    s4p = '0;
    for (int k = 0; k < 8; k++)
      s4p[k] = m3 ? d3[k] : mmul(d3[k], t3[k]);
  end

  always_comb begin
    s4 = s4p;
`ifdef RADIX8_NTT_INV_EN
    if (i3)
      for (int k = 0; k < 8; k++)
        s4[k] = mmul(s4p[k], EI);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0 <= 1'b0; m0 <= 1'b0; i0 <= 1'b0;
      v1 <= 1'b0; m1 <= 1'b0; i1 <= 1'b0;
      v2 <= 1'b0; m2 <= 1'b0; i2 <= 1'b0;
      v3 <= 1'b0; m3 <= 1'b0; i3 <= 1'b0;
      a0r <= '0; t0r <= '0;
      d1 <= '0; t1 <= '0;
      d2 <= '0; t2 <= '0;
      d3 <= '0; t3 <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
    end else if (adv) begin
      v0 <= in_valid; m0 <= in_mode; i0 <= inv_in;
      a0r <= in_a; t0r <= in_tf;
      v1 <= v0; m1 <= m0; i1 <= i0;
      d1 <= s1a; t1 <= s1t;
      v2 <= v1; m2 <= m1; i2 <= i1;
      d2 <= s2; t2 <= t1;
      v3 <= v2; m3 <= m2; i3 <= i2;
      d3 <= s3; t3 <= t2;
      out_valid <= v3;
      out_a <= s4;
    end
  end

endmodule

// File: tb/tb_radix_8_ntt_pipe.sv
// tb_radix_8_ntt_pipe: directed and random beats checked against a direct
// 8-point DFT-sum reference model with a FIFO scoreboard.
module tb_radix_8_ntt_pipe;

  localparam int L = 17;
  localparam longint unsigned Q = 65537;
  localparam longint unsigned W8 = 16;
  localparam longint unsigned W8INV = 61441;
  localparam longint unsigned EIGHTINV = 57345;
`ifdef RADIX8_NTT_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef logic [8*L-1:0] blk_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_mode, in_inv;
  logic out_valid, out_ready;
  blk_t in_a, in_tf, out_a;

  int n_assert = 0;
  int n_fail = 0;
  blk_t exp_q[$];
  bit accepted;
  bit hold_v;
  blk_t hold_a;
  bit last_ov;

  always #5 clk = ~clk;

  radix_8_ntt_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_inv(in_inv),
    .in_a(in_a), .in_tf(in_tf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a)
  );

  task automatic check(input string tag, input blk_t obs, input blk_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic blk_t pk(input longint unsigned c0, c1, c2, c3,
                              c4, c5, c6, c7);
    return {L'(c7), L'(c6), L'(c5), L'(c4),
            L'(c3), L'(c2), L'(c1), L'(c0)};
  endfunction

  function automatic blk_t rand_blk();
    blk_t r;
    r = '0;
    for (int k = 0; k < 8; k++)
      r[k*L +: L] = L'($urandom_range(0, 131071));
    return r;
  endfunction

  // A_k = s * [tf_k] * sum_j a_j * [tf_j] * w^(jk) mod Q
  function automatic blk_t model(input blk_t a, input blk_t tf,
                                 input bit mode, input bit inv);
    longint unsigned av[8], tv[8], wp[8];
    longint unsigned w, s, acc, x;
    blk_t r;
    r = '0;
    w = W8;
    s = 1;
    if (inv && INV_EN) begin
      w = W8INV;
      s = EIGHTINV;
    end
    for (int j = 0; j < 8; j++) begin
      av[j] = 64'(a[j*L +: L]);
      tv[j] = 64'(tf[j*L +: L]);
      if (av[j] >= Q) av[j] = av[j] - Q;
      if (tv[j] >= Q) tv[j] = tv[j] - Q;
    end
    wp[0] = 1;
    for (int k = 1; k < 8; k++) wp[k] = (wp[k-1] * w) % Q;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int j = 0; j < 8; j++) begin
        x = mode ? (av[j] * tv[j]) % Q : av[j];
        acc = (acc + x * wp[(j*k) % 8]) % Q;
      end
      if (!mode) acc = (acc * tv[k]) % Q;
      acc = (acc * s) % Q;
      r[k*L +: L] = acc[L-1:0];
    end
    return r;
  endfunction

  // One clock: check outputs at negedge, log acceptance, step past posedge.
  task automatic cycle();
    @(negedge clk);
    last_ov = out_valid;
    if (hold_v) begin
      check("hold_valid", blk_t'(out_valid), blk_t'(1));
      check("hold_data", out_a, hold_a);
    end
    if (out_valid && !out_ready)
      check("in_ready_stall", blk_t'(in_ready), blk_t'(0));
    else
      check("in_ready_free", blk_t'(in_ready), blk_t'(1));
    if (out_valid) begin
      if (exp_q.size() == 0)
        check("spurious_out", blk_t'(out_valid), blk_t'(0));
      else begin
        check("out_a", out_a, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    hold_v = out_valid && !out_ready;
    hold_a = out_a;
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(model(in_a, in_tf, in_mode, in_inv));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 60) begin
      cycle();
      n++;
    end
  endtask

  task automatic single(input string tag, input blk_t a, input blk_t tf,
                        input bit mode, input bit inv, input blk_t want);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = mode;
    in_inv = inv;
    in_a = a;
    in_tf = tf;
    cycle();
    in_valid = 1'b0;
    in_a = rand_blk();
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      @(negedge clk);
    end
    check({tag, "_latency"}, blk_t'(n), blk_t'(4));
    check(tag, out_a, want);
    if (exp_q.size() > 0) check({tag, "_model"}, out_a, exp_q.pop_front());
    else check({tag, "_accepted"}, blk_t'(0), blk_t'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t ones, fwd, tfk, want;
    int n, sent;
    bit need;
    ones = pk(1, 1, 1, 1, 1, 1, 1, 1);
    fwd = pk(1, 16, 256, 4096, 65536, 65521, 65281, 61441);
    tfk = pk(1, 2, 3, 4, 5, 6, 7, 8);
    hold_v = 1'b0;
    hold_a = '0;

    rst_n = 1'b0;
    in_valid = 1'b1;
    in_mode = 1'b0;
    in_inv = 1'b0;
    out_ready = 1'b1;
    in_a = rand_blk();
    in_tf = rand_blk();
    @(posedge clk);
    #1;
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", blk_t'(out_valid), blk_t'(0));
      check("rst_out_a", out_a, '0);
      check("rst_in_ready", blk_t'(in_ready), blk_t'(1));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (6) begin
      cycle();
      check("post_rst_quiet", blk_t'(last_ov), blk_t'(0));
    end

    single("dif_fwd", pk(0, 1, 0, 0, 0, 0, 0, 0), ones, 1'b0, 1'b0, fwd);
    single("dit_reduce", pk(65537, 1, 1, 1, 1, 1, 1, 1), ones, 1'b1,
           1'b0, pk(7, 65536, 65536, 65536, 65536, 65536, 65536, 65536));
    want = INV_EN ? pk(0, 1, 0, 0, 0, 0, 0, 0) : model(fwd, ones, 1'b0, 1'b0);
    single("inverse", fwd, ones, 1'b0, 1'b1, want);

    // Back-to-back beats alternating DIF and DIT.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode = i[0];
      in_inv = 1'b0;
      in_a = rand_blk();
      in_tf = tfk;
      cycle();
    end
    drain(n);
    check("mixed_drain_cycles", blk_t'(n), blk_t'(5));

    // Six beats with a three-cycle output stall mid-stream.
    sent = 0;
    need = 1'b1;
    for (int t = 0; t < 40 && (sent < 6 || exp_q.size() > 0); t++) begin
      if (need) begin
        in_a = rand_blk();
        in_tf = rand_blk();
        in_mode = $urandom_range(0, 1) == 1;
        in_inv = 1'b0;
      end
      in_valid = sent < 6;
      out_ready = !(t >= 5 && t <= 7);
      cycle();
      need = accepted;
      if (accepted) sent++;
    end
    check("bp_sent", blk_t'(sent), blk_t'(6));
    check("bp_all_out", blk_t'(exp_q.size()), blk_t'(0));

    // Random valid/ready/mode/inv traffic.
    sent = 0;
    need = 1'b1;
    for (int t = 0; t < 400 && sent < 40; t++) begin
      if (need) begin
        in_a = rand_blk();
        in_tf = rand_blk();
        in_mode = $urandom_range(0, 1) == 1;
        in_inv = $urandom_range(0, 1) == 1;
        in_valid = $urandom_range(0, 9) < 7;
      end
      out_ready = $urandom_range(0, 9) < 7;
      cycle();
      need = accepted || !in_valid;
      if (accepted) sent++;
    end
    drain(n);
    check("rand_sent", blk_t'(sent), blk_t'(40));
    check("rand_all_out", blk_t'(exp_q.size()), blk_t'(0));

    // Reset with beats in flight: nothing may emerge afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_mode = i[0];
      in_inv = 1'b0;
      in_a = rand_blk();
      in_tf = rand_blk();
      cycle();
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    hold_v = 1'b0;
    repeat (8) begin
      cycle();
      check("mid_rst_quiet", blk_t'(last_ov), blk_t'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/radix_8_ntt_pipe.md
# radix_8_ntt_pipe

Pipelined, parametrised radix-8 NTT butterfly engine with valid/ready flow control, per-beat DIF/DIT mode selection and an optional inverse mode. Accepts one 8-point block per cycle and produces one 8-point block per cycle after a fixed 4-cycle latency. It is the streaming successor to the combinational radix-8 DIF butterfly and is intended to be driven by the NTT stage controller and coefficient memory banks.

## Interface
- `LOGQ`, 17: coefficient width in bits; requires Q < 2^LOGQ < 2Q.
- `Q`, 65537: prime modulus.
- `W8`, 16: primitive 8th root of unity mod Q.
- `W8INV`, 61441: W8^-1 mod Q.
- `EIGHTINV`, 57345: 8^-1 mod Q.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  engine accepts the beat this cycle.
- `in_mode`  in  1  0 = DIF (twiddle after butterfly), 1 = DIT (twiddle before butterfly).
- `in_inv`  in  1  inverse transform select; used only with `RADIX8_NTT_INV_EN`.
- `in_a`  in  8*LOGQ  coefficients a0..a7, with a0 in bits [LOGQ-1:0].
- `in_tf`  in  8*LOGQ  twiddles tf0..tf7, packed the same way.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts the beat.
- `out_a`  out  8*LOGQ  results A0..A7 in natural order, canonical in [0, Q-1].

## Operation
- Define w = W8, or w = W8INV when the beat is inverse. All arithmetic is mod Q.
- DIF: A_k = s * tf_k * Σ_j a_j·w^(jk).
- DIT: A_k = s * Σ_j (a_j·tf_j)·w^(jk).
- Scale s is 1 for forward beats and EIGHTINV for inverse beats.
- Input reduction: any a_j or tf_j ≥ Q is reduced by one conditional subtraction of Q at stage 1. Because 2^LOGQ < 2Q, this always yields a canonical value.
- Pipeline stages; every stage register carries valid, mode and inv with the data:
  - S1: reduce inputs; if DIT, multiply a_j·tf_j, otherwise pass a_j through. tf is carried forward.
  - S2: radix-2 layer 1, pairs (j, j+4).
  - S3: radix-2 layers 2 and 3, applying internal factors w^2 and w^1/w^3 as constant multiplies mod Q. Outputs are in natural order.
  - S4: if DIF, multiply by tf_k; if inverse, multiply by EIGHTINV. Registered to `out_a`.
- Flow control: adv = !out_valid || out_ready.
  - When adv is high, all stages shift by one and `in_ready` = adv.
  - When adv is low, every register holds its value.
  - Bubbles (valid = 0) propagate without being squeezed out. Keeping one global enable is a deliberate choice for simplicity.
- Mode and inv are sampled per beat, so back-to-back beats may mix modes freely.
- Reset: all valid bits, data, mode and inv registers clear to 0. Outputs after reset: `out_valid` = 0, `out_a` = 0, `in_ready` = 1.
- Reset asserted mid-stream discards all in-flight beats; no partial beat is emitted.

## Timing
- Latency: a beat accepted at edge n appears with `out_valid` = 1 after edge n+4, when there is no stall.
- Throughput: 1 beat per cycle.
- A stall of k cycles delays every in-flight beat by exactly k cycles.
- `out_a` and `out_valid` are stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` is combinational from `out_valid` and `out_ready`; there is no other combinational input-to-output path.
- `in_a` and `in_tf` are ignored when `in_valid` = 0 or `in_ready` = 0.

## Configuration
- `RADIX8_NTT_INV_EN`:
  - Defined: `in_inv` is honoured; inverse beats use W8INV and the EIGHTINV scaling in S4.
  - Undefined: `in_inv` is ignored, inv is treated as 0, and the EIGHTINV multiplier and W8INV constants are not built. Latency is unchanged.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles while driving `in_valid` = 1 → `out_valid` = 0, `out_a` = 0 and `in_ready` = 1 throughout; no output appears afterwards.
- DIF forward: a = (0,1,0,0,0,0,0,0), tf all 1 → 4 cycles later A = (1, 16, 256, 4096, 65536, 65521, 65281, 61441).
- DIT forward with reduction: a0 = 65537, a1..a7 = 1, tf all 1 → A0 = 7, A1..A7 = 65536 (i.e. −1).
- Back-to-back mixed modes: 8 consecutive beats alternating DIF and DIT, with tf_k = k+1 → each result matches the golden model for its own mode, in order, one result per cycle.
- Backpressure: stream 6 beats, drop `out_ready` for 3 cycles mid-stream → `in_ready` = 0 during the stall, the held output is stable, and there is no loss, duplication or reorder.
- Inverse (`RADIX8_NTT_INV_EN` defined): feed the DIF forward result with tf all 1 and inv = 1 → A = (0,1,0,0,0,0,0,0). With the macro undefined, the same stimulus yields the forward transform of that input.
